wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 136 +++++++++++++
 tb/tb_wb_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Round-robin write-back arbiter: per-channel FIFOs merged into one registered output, 1 cycle FIFO-to-output.
// Writes never stall; a write into a full FIFO is dropped and flagged, and the output holds while out_ready is low.

module wb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         drop
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          full, do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & ~do_push;
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module wb_arbiter #(
  parameter int CHANNEL_NUM = 4,
  parameter int MULT_BITS   = 32,
  parameter int ROW_ID_BITS = 10,
  parameter int FIFO_DEPTH  = 4,
  localparam int CW = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [MULT_BITS*CHANNEL_NUM-1:0]   wr_data,
  input  logic [ROW_ID_BITS*CHANNEL_NUM-1:0] wr_addr,
  input  logic [CHANNEL_NUM-1:0]             wr_en,
  output logic [MULT_BITS-1:0]               out_data,
  output logic [ROW_ID_BITS-1:0]             out_addr,
  output logic [CW-1:0]                      out_ch,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [CHANNEL_NUM-1:0]             overflow,
  output logic                               idle
);
  localparam int EW = ROW_ID_BITS + MULT_BITS;

  logic [EW-1:0]          head [CHANNEL_NUM];
  logic [CHANNEL_NUM-1:0] empty, nonempty, pop, drop;
  logic [CW-1:0]          rr_ptr, gnt, cand, rr_next;
  logic                   gnt_vld, load;

  genvar i;
  generate
    for (i = 0; i < CHANNEL_NUM; i++) begin : g_ch
      wb_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en[i]),
        .pop   (pop[i]),
        .din   ({wr_addr[i*ROW_ID_BITS +: ROW_ID_BITS], wr_data[i*MULT_BITS +: MULT_BITS]}),
        .dout  (head[i]),
        .empty (empty[i]),
        .drop  (drop[i])
      );
      assign pop[i] = load & gnt_vld & (gnt == CW'(i));
    end
  endgenerate

  assign nonempty = ~empty;
  assign load     = ~out_valid | out_ready;
  assign idle     = ~(|nonempty) & ~out_valid;
  assign rr_next  = (gnt == CW'(CHANNEL_NUM - 1)) ? '0 : gnt + 1'b1;

  // First non-empty channel at or after rr_ptr, wrapping.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    cand    = '0;
    for (int k = 0; k < CHANNEL_NUM; k++) begin
      cand = CW'((int'(rr_ptr) + k) % CHANNEL_NUM);
      if (!gnt_vld && nonempty[cand]) begin
        gnt_vld = 1'b1;
        gnt     = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
      overflow  <= '0;
    end else begin
      if (load) begin
        out_valid <= gnt_vld;
        if (gnt_vld) begin
          {out_addr, out_data} <= head[gnt];
          out_ch               <= gnt;
          rr_ptr               <= rr_next;
        end
      end
      overflow <= overflow | drop;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with hand-computed expectations.
module tb_wb_arbiter;
  localparam int N  = 4;
  localparam int MB = 32;
  localparam int RB = 10;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [MB*N-1:0] wr_data = '0;
  logic [RB*N-1:0] wr_addr = '0;
  logic [N-1:0]    wr_en = '0;
  logic [MB-1:0]   out_data;
  logic [RB-1:0]   out_addr;
  logic [1:0]      out_ch;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [N-1:0]    overflow;
  logic            idle;

  int passed = 0;
  int total  = 0;

  wb_arbiter #(.CHANNEL_NUM(N), .MULT_BITS(MB), .ROW_ID_BITS(RB), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_data   (wr_data),
    .wr_addr   (wr_addr),
    .wr_en     (wr_en),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input int addr, input int data);
    wr_addr[ch*RB +: RB] = RB'(addr);
    wr_data[ch*MB +: MB] = MB'(data);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    wr_en = '0;
    out_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_idle", idle, 1);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", out_data, 0);
    chk("rst_addr", out_addr, 0);
    step();
    rst = 1'b1;
    step();

    // Single write: one-cycle FIFO-to-output latency
    out_ready = 1'b1;
    set_ch(0, 5, 'h10);
    wr_en = 4'b0001;
    step();
    wr_en = '0;
    chk("single_early", out_valid, 0);
    step();
    chk("single_valid", out_valid, 1);
    chk("single_addr", out_addr, 5);
    chk("single_data", out_data, 'h10);
    chk("single_ch", out_ch, 0);
    chk("single_busy", idle, 0);
    step();
    chk("single_done", out_valid, 0);
    chk("single_idle", idle, 1);

    // Round robin across all channels
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < N; c++) set_ch(c, c, 'h100 + c);
    wr_en = 4'b1111;
    step();
    wr_en = '0;
    for (int c = 0; c < N; c++) begin
      step();
      chk("rr_ch", out_ch, c);
      chk("rr_addr", out_addr, c);
      chk("rr_data", out_data, 'h100 + c);
    end
    step();
    chk("rr_empty", out_valid, 0);
    // Pointer wrapped to 0: ch0 must win over ch3
    set_ch(0, 20, 'h200);
    set_ch(3, 23, 'h203);
    wr_en = 4'b1001;
    step();
    wr_en = '0;
    step();
    chk("wrap_first", out_ch, 0);
    step();
    chk("wrap_second", out_ch, 3);

    // Backpressure: ch2 pushes 4 words with output stalled
    do_reset();
    wr_en = 4'b0100;
    for (int a = 1; a <= 4; a++) begin
      set_ch(2, a, 'h30 + a);
      step();
    end
    wr_en = '0;
    for (int k = 0; k < 6; k++) begin
      chk("bp_hold", out_addr, 1);
      step();
    end
    chk("bp_valid", out_valid, 1);
    chk("bp_ch", out_ch, 2);
    chk("bp_ovf", overflow, 0);
    out_ready = 1'b1;
    for (int a = 2; a <= 4; a++) begin
      step();
      chk("bp_order", out_addr, a);
      chk("bp_data", out_data, 'h30 + a);
    end
    step();
    chk("bp_drained", out_valid, 0);

    // Overflow: 6 pushes into depth-4 FIFO plus output register
    do_reset();
    wr_en = 4'b0010;
    for (int a = 1; a <= 6; a++) begin
      set_ch(1, a, 'h40 + a);
      step();
    end
    wr_en = '0;
    chk("ovf_flag", overflow, 4'b0010);
    chk("ovf_head", out_addr, 1);
    out_ready = 1'b1;
    for (int a = 2; a <= 5; a++) begin
      step();
      chk("ovf_order", out_addr, a);
    end
    step();
    chk("ovf_only5", out_valid, 0);
    chk("ovf_sticky", overflow, 4'b0010);

    // Full FIFO with simultaneous pop and push
    do_reset();
    chk("ovf_cleared", overflow, 0);
    wr_en = 4'b0001;
    for (int a = 1; a <= 5; a++) begin
      set_ch(0, a, 'h50 + a);
      step();
    end
    out_ready = 1'b1;
    set_ch(0, 6, 'h56);
    step();
    wr_en = '0;
    chk("full_pp_ovf", overflow, 0);
    chk("full_pp_head", out_addr, 2);
    for (int a = 3; a <= 6; a++) begin
      step();
      chk("full_pp_order", out_addr, a);
    end
    chk("full_pp_kept", out_data, 'h56);
    step();
    chk("full_pp_drained", out_valid, 0);

    // Asynchronous reset between edges with 3 words in flight
    do_reset();
    wr_en = 4'b1000;
    for (int a = 1; a <= 3; a++) begin
      set_ch(3, a, 'h60 + a);
      step();
    end
    wr_en = '0;
    chk("ar_pre_valid", out_valid, 1);
    #3;
    rst = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_idle", idle, 1);
    chk("ar_addr", out_addr, 0);
    #2;
    rst = 1'b1;
    out_ready = 1'b1;
    step();
    chk("ar_post_valid", out_valid, 0);
    step();
    chk("ar_post_idle", idle, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
